// File: rtl/arith_pkg.sv
`default_nettype none
// =============================================================================
// Package : arith_pkg
// Purpose : Types, constants and helpers shared by the pipelined prefix
//           arithmetic blocks.
//   SUB_PIPE_STAGES : register stages between operand capture and result
//   gp_t            : {generate, propagate} pair carried through prefix trees
//   log2_ceil()     : tree depth for a given operand width
// Revision: 1.0 - initial release
// =============================================================================
package arith_pkg;

  localparam int SUB_PIPE_STAGES = 3;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Smallest r with 2**r >= n; constant-foldable so it can size generate trees.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gp_cell.sv
`default_nettype none
// =============================================================================
// Module  : gp_cell
// Purpose : Prefix-tree black cell. Merges a high-order {G,P} group with the
//           adjacent low-order group. Used as a grey cell by ignoring gp_o.p.
// Ports   :
//   hi_i  in  gp_t  more-significant group
//   lo_i  in  gp_t  less-significant group
//   gp_o  out gp_t  merged group
// Revision: 1.0 - initial release
// =============================================================================
module gp_cell
  import arith_pkg::*;
(
  input  gp_t hi_i,
  input  gp_t lo_i,
  output gp_t gp_o
);

  assign gp_o.g = hi_i.g | (hi_i.p & lo_i.g);
  assign gp_o.p = hi_i.p & lo_i.p;

endmodule
`default_nettype wire

// File: rtl/sub8_brent_kung_pipe.sv
`default_nettype none
// =============================================================================
// Module  : sub8_brent_kung_pipe
// Purpose : Three-stage pipelined subtractor Z = X - Y - BorrowIn, computed as
//           X + ~Y + ~BorrowIn on a Brent-Kung prefix network. A single global
//           stall (result held, not acknowledged) freezes every stage.
// Ports   :
//   clk         in   clock, rising edge
//   resetn      in   asynchronous active-low reset
//   iValid      in   operand strobe
//   oAccept     out  operands are taken this cycle
//   iX, iY      in   minuend, subtrahend (N bits)
//   iBorrowIn   in   borrow into bit 0
//   oZ          out  difference mod 2^N
//   oBorrowOut  out  unsigned borrow out of the MSB
//   oOverflow   out  signed overflow
//   oReady      out  result valid
//   iAck        in   result consumed this cycle
// Revision: 1.0 - initial release
// =============================================================================
module sub8_brent_kung_pipe
  import arith_pkg::*;
#(
  parameter int N = 8
)
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         iValid,
  output logic         oAccept,
  input  logic [N-1:0] iX,
  input  logic [N-1:0] iY,
  input  logic         iBorrowIn,
  output logic [N-1:0] oZ,
  output logic         oBorrowOut,
  output logic         oOverflow,
  output logic         oReady,
  input  logic         iAck
);

  localparam int LOGN = log2_ceil(N);

  logic w_stall;

  // Stage 0 : operand capture (Y inverted, borrow turned into carry)
  logic [N-1:0] x0_q, yn0_q;
  logic         cin0_q, v0_q;

  // Stage 1 : up-sweep results
  logic [N-1:0] w_prop, w_gen;
  logic [N-1:0] w_up_g, w_up_p;
  logic [N-1:0] ug1_q, up1_q, p1_q;
  logic         cin1_q, xmsb1_q, ymsb1_q, v1_q;

  // Stage 2 : down-sweep, sum and output registers
  logic [N-1:0] w_pre_g, w_pre_p;
  logic [N-1:0] w_carry;
  logic [N-1:0] z_d, z2_q;
  logic         bout_d, ovf_d;
  logic         bout2_q, ovf2_q, rdy2_q;
  logic         w_unused_pre_p;

  assign w_stall = rdy2_q & ~iAck;
  assign oAccept = ~w_stall;

  // ---------------------------------------------------------------------------
  // Stage 0
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0_q   <= '0;
      yn0_q  <= '0;
      cin0_q <= 1'b0;
      v0_q   <= 1'b0;
    end else if (!w_stall) begin
      x0_q   <= iX;
      yn0_q  <= ~iY;
      cin0_q <= ~iBorrowIn;
      v0_q   <= iValid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 : bitwise g/p and Brent-Kung up-sweep.
  // Level 0 folds the carry-in into bit 0 so that every prefix generate
  // already accounts for it and c[i] = G[i-1:0] needs no extra term.
  // ---------------------------------------------------------------------------
  assign w_prop = x0_q ^ yn0_q;
  assign w_gen  = x0_q & yn0_q;

  for (genvar l = 0; l <= LOGN; l++) begin : g_up
    gp_t w_lvl [N];
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (l == 0) begin : g_base
        if (i == 0) begin : g_fold
          assign w_lvl[i] = '{g: w_gen[i] | (w_prop[i] & cin0_q), p: w_prop[i]};
        end else begin : g_plain
          assign w_lvl[i] = '{g: w_gen[i], p: w_prop[i]};
        end
      end else if (((i + 1) % (1 << l)) == 0) begin : g_cell
        gp_cell u_cell (
          .hi_i (g_up[l-1].w_lvl[i]),
          .lo_i (g_up[l-1].w_lvl[i - (1 << (l - 1))]),
          .gp_o (w_lvl[i])
        );
      end else begin : g_pass
        assign w_lvl[i] = g_up[l-1].w_lvl[i];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_up_out
    assign w_up_g[i] = g_up[LOGN].w_lvl[i].g;
    assign w_up_p[i] = g_up[LOGN].w_lvl[i].p;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ug1_q   <= '0;
      up1_q   <= '0;
      p1_q    <= '0;
      cin1_q  <= 1'b0;
      xmsb1_q <= 1'b0;
      ymsb1_q <= 1'b0;
      v1_q    <= 1'b0;
    end else if (!w_stall) begin
      ug1_q   <= w_up_g;
      up1_q   <= w_up_p;
      p1_q    <= w_prop;
      cin1_q  <= cin0_q;
      xmsb1_q <= x0_q[N-1];
      ymsb1_q <= ~yn0_q[N-1];
      v1_q    <= v0_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 : down-sweep. At tree level l, node i = k*2^l + 2^(l-1) - 1 (k>=1)
  // merges with the complete prefix ending at bit k*2^l - 1.
  // ---------------------------------------------------------------------------
  for (genvar d = 0; d < LOGN; d++) begin : g_dn
    gp_t w_lvl [N];
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (d == 0) begin : g_base
        assign w_lvl[i] = '{g: ug1_q[i], p: up1_q[i]};
      end else begin : g_level
        localparam int L = LOGN - d;
        if ((i >= (1 << L)) && (((i + 1) % (1 << L)) == (1 << (L - 1)))) begin : g_cell
          gp_cell u_cell (
            .hi_i (g_dn[d-1].w_lvl[i]),
            .lo_i (g_dn[d-1].w_lvl[i - (1 << (L - 1))]),
            .gp_o (w_lvl[i])
          );
        end else begin : g_pass
          assign w_lvl[i] = g_dn[d-1].w_lvl[i];
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pre
    assign w_pre_g[i] = g_dn[LOGN-1].w_lvl[i].g;
    assign w_pre_p[i] = g_dn[LOGN-1].w_lvl[i].p;
  end

  // Full-prefix propagates are never needed once carries are formed.
  assign w_unused_pre_p = ^w_pre_p;

  assign w_carry = {w_pre_g[N-2:0], cin1_q};
  assign z_d     = p1_q ^ w_carry;
  assign bout_d  = ~w_pre_g[N-1];
  assign ovf_d   = (xmsb1_q != ymsb1_q) & (z_d[N-1] != xmsb1_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      z2_q    <= '0;
      bout2_q <= 1'b0;
      ovf2_q  <= 1'b0;
      rdy2_q  <= 1'b0;
    end else if (!w_stall) begin
      z2_q    <= z_d;
      bout2_q <= bout_d;
      ovf2_q  <= ovf_d;
      rdy2_q  <= v1_q;
    end
  end

  assign oZ         = z2_q;
  assign oBorrowOut = bout2_q;
  assign oOverflow  = ovf2_q;
  assign oReady     = rdy2_q;

endmodule
`default_nettype wire

// File: doc/sub8_brent_kung_pipe.md
Name: sub8_brent_kung_pipe

Overview:
- Pipelined N-bit two's-complement subtractor; the inverse of the Brent-Kung adder. Computes Z = X - Y - BorrowIn.
- Implemented as X + ~Y + ~BorrowIn on a Brent-Kung prefix carry network, split over three register stages.
- Adds a valid/accept/ack handshake with full backpressure, so it can sit between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
- N, 8, operand width. Legal values are 4, 8 and 16 (power of two for the Brent-Kung tree).

Ports:
- clk  input  1  clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- iValid  input  1  operand-valid strobe.
- oAccept  output  1  block can take operands this cycle.
- iX  input  N  minuend.
- iY  input  N  subtrahend.
- iBorrowIn  input  1  borrow into bit 0.
- oZ  output  N  difference, mod 2^N.
- oBorrowOut  output  1  borrow out of the MSB; 1 when X < Y + BorrowIn (unsigned).
- oOverflow  output  1  signed overflow.
- oReady  output  1  result valid on oZ, oBorrowOut and oOverflow.
- iAck  input  1  downstream consumes the result this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on resetn.
- Reset values:
  - All stage valid bits = 0, all data registers = 0.
  - oZ = 0, oBorrowOut = 0, oOverflow = 0, oReady = 0.
  - oAccept = 1, because oAccept is combinational and oReady = 0.
- Stall and accept:
  - stall = oReady & ~iAck. It is global: every stage holds while stall = 1.
  - oAccept = ~stall.
  - A transfer-in occurs when iValid & oAccept.
  - A transfer-out occurs when oReady & iAck.
- Stage S0 (input register, when ~stall):
  - Captures iX, ~iY, cin = ~iBorrowIn, and v0 = iValid.
  - If iValid = 0, data registers may hold their old values; only the valid bit matters.
- Stage S1 (when ~stall):
  - Computes bitwise p = x ^ y', g = x & y'.
  - Applies the Brent-Kung up-sweep: levels 1..log2(N).
  - Folds cin into the bit-0 generate: g0' = g0 | (p0 & cin).
  - Registers the up-sweep G/P, the raw p, cin, the MSB operand bits, and v1 = v0.
- Stage S2 (when ~stall):
  - Applies the down-sweep: log2(N)-1 levels.
  - Forms carries c[0] = cin and c[i] = G[i-1:0].
  - Forms sum = p ^ c and cout = G[N-1:0].
  - Registers the outputs:
    - oZ = sum.
    - oBorrowOut = ~cout.
    - oOverflow = (X[N-1] != Y[N-1]) & (Z[N-1] != X[N-1]).
    - oReady = v1.
- Latency: 3 clk edges from transfer-in to oReady = 1 with no stall. Throughput is one result per cycle.
- Backpressure:
  - While oReady = 1 and iAck = 0, oZ, oBorrowOut, oOverflow and oReady hold, and S0/S1 hold.
  - No result is lost or duplicated.
  - iValid and operands presented while oAccept = 0 are ignored; the producer must hold them.
- Simultaneous events: iAck = 1 in the same cycle as a new transfer-in is legal. The pipe advances and the held result is replaced.
- Bubbles:
  - Invalid slots propagate as oReady = 0.
  - With oReady = 0, stall = 0 regardless of iAck. iAck is don't-care when oReady = 0.
- Reset mid-operation: in-flight results are discarded and all valids clear immediately (asynchronous). The first post-reset result appears 3 cycles after the first post-reset transfer-in.
- Arithmetic boundaries:
  - 0 - 1 = 2^N-1 with oBorrowOut = 1.
  - X = Y with iBorrowIn = 0 gives 0, oBorrowOut = 0.
  - X = Y with iBorrowIn = 1 gives 2^N-1, oBorrowOut = 1.

Decomposition:
- Shared package arith_pkg:
  - Constant SUB_PIPE_STAGES = 3.
  - Constant LOG2 helper for tree depth.
  - A gp_t struct type holding {g, p}.
- Sub-module gp_cell: the Brent-Kung black cell.
  - Go = Ghi | (Phi & Glo), Po = Phi & Plo.
  - The tree is instanced by generate loops. Grey (G-only) cells are the same module with Po unused.

Test Plan:
- X=0x05, Y=0x03, Bin=0, single op, iAck=1 -> 3 cycles later oReady=1, oZ=0x02, oBorrowOut=0, oOverflow=0.
- X=0x00, Y=0x01, Bin=0 -> oZ=0xFF, oBorrowOut=1, oOverflow=0.
- X=0x80, Y=0x01 -> oZ=0x7F, oBorrowOut=0, oOverflow=1. Also X=0x7F, Y=0xFF -> oZ=0x80, oOverflow=1, oBorrowOut=1.
- X=0x10, Y=0x0F, Bin=1 -> oZ=0x00, oBorrowOut=0. X=0x10, Y=0x10, Bin=1 -> oZ=0xFF, oBorrowOut=1.
- Backpressure:
  - Stimulus: stream ops (1,1), (9,2), (3,5) back-to-back; hold iAck=0 for 2 cycles once the first result appears.
  - Required: oZ stays 0x00 with oAccept=0 during the hold; then 0x00, 0x07, 0xFE are delivered in order with no loss or duplicate.
- Reset mid-flight:
  - Stimulus: assert resetn=0 asynchronously with 3 ops in flight.
  - Required: oReady=0 and oZ=0 immediately, oAccept=1.
  - After release, a new op (0x20 - 0x01) gives oZ=0x1F exactly 3 cycles after acceptance.
